// File: rtl/npc_bpu_pkg.sv
// Shared branch definitions for the next-PC / branch prediction slice.
// Holds the BRANCH_SEL_* condition codes and the branch condition evaluator.
package npc_bpu_pkg;

    localparam logic [3:0] BRANCH_SEL_BEQ    = 4'd0;
    localparam logic [3:0] BRANCH_SEL_BNE    = 4'd1;
    localparam logic [3:0] BRANCH_SEL_BGEZ   = 4'd2;
    localparam logic [3:0] BRANCH_SEL_BGTZ   = 4'd3;
    localparam logic [3:0] BRANCH_SEL_BLEZ   = 4'd4;
    localparam logic [3:0] BRANCH_SEL_BLTZ   = 4'd5;
    localparam logic [3:0] BRANCH_SEL_BGEZAL = 4'd6;
    localparam logic [3:0] BRANCH_SEL_BLTZAL = 4'd7;

    // Signed compares against zero only need the sign bit and a zero test.
    function automatic logic branch_cond(
        input logic [3:0]  sel,
        input logic [31:0] rs,
        input logic [31:0] rt
    );
        logic neg;
        logic zero;
        logic res;
        neg  = rs[31];
        zero = (rs == 32'd0);
        case (sel)
            BRANCH_SEL_BEQ:    res = (rs == rt);
            BRANCH_SEL_BNE:    res = (rs != rt);
            BRANCH_SEL_BGEZ:   res = !neg;
            BRANCH_SEL_BGTZ:   res = !neg && !zero;
            BRANCH_SEL_BLEZ:   res = neg || zero;
            BRANCH_SEL_BLTZ:   res = neg;
            BRANCH_SEL_BGEZAL: res = !neg;
            BRANCH_SEL_BLTZAL: res = neg;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped BTB: valid/tag/target/2-bit counter per entry.
// Ports: rd_* combinational lookup (hit, predicted taken, target);
//        wr_* training port applied at posedge; resetn clears all valid bits.
module npc_btb
    import npc_bpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target
);

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag    [DEPTH];
    logic [31:0]      target [DEPTH];
    logic [1:0]       ctr    [DEPTH];

    logic wr_hit;

    assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    assign rd_taken  = rd_hit && ctr[rd_idx][1];
    assign rd_target = rd_hit ? target[rd_idx] : 32'd0;

    assign wr_hit = valid[wr_idx] && (tag[wr_idx] == wr_tag);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= '0;
        end else if (wr_en) begin
            if (wr_hit) begin
                if (wr_taken) begin
                    target[wr_idx] <= wr_target;
                    if (ctr[wr_idx] != 2'b11)
                        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
                end else if (ctr[wr_idx] != 2'b00) begin
                    ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
                end
            end else if (wr_taken) begin
                valid[wr_idx]  <= 1'b1;
                tag[wr_idx]    <= wr_tag;
                target[wr_idx] <= wr_target;
                ctr[wr_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: rtl/npc_bpu.sv
// Next-PC generator: owns the fetch PC, resolves ID2 control transfers,
// detects mispredictions, trains the BTB and drives flush_req.
// Ports: exception and ID2 resolve inputs; pc/next_pc, BTB prediction
//        for the current pc, and flush_req outputs.
module npc_bpu
    import npc_bpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          BTB_DEPTH   = 16,
    parameter int          FETCH_BYTES = 8,
    parameter int          TAG_W       = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_stall,
    input  logic        exception_pc_ena,
    input  logic [31:0] exception_pc,
    input  logic        id2_valid,
    input  logic [31:0] id2_pc,
    input  logic        id2_is_branch,
    input  logic        id2_is_jr,
    input  logic        id2_is_j_imme,
    input  logic [3:0]  id2_branch_sel,
    input  logic [31:0] id2_rs_data,
    input  logic [31:0] id2_rt_data,
    input  logic [31:0] id2_jmp_target,
    input  logic        id2_pred_taken,
    input  logic [31:0] id2_pred_target,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] next_pc,
    output logic        flush_req
);

    localparam int          IDX_W = $clog2(BTB_DEPTH);
    localparam logic [31:0] FB    = 32'(FETCH_BYTES);

    logic is_cti;
    logic taken;
    logic mispred;
    logic train;
    logic hit;

    assign is_cti = id2_is_branch || id2_is_jr || id2_is_j_imme;
    assign taken  = id2_is_jr || id2_is_j_imme ||
                    (id2_is_branch &&
                     branch_cond(id2_branch_sel, id2_rs_data, id2_rt_data));

    assign mispred = id2_valid &&
                     ((taken != id2_pred_taken) ||
                      (taken && (id2_jmp_target != id2_pred_target)));

    assign flush_req = exception_pc_ena || mispred;
    assign train     = id2_valid && !exception_pc_ena && is_cti;

    npc_btb #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (pc[IDX_W+1:2]),
        .rd_tag    (pc[IDX_W+2 +: TAG_W]),
        .rd_hit    (hit),
        .rd_taken  (pred_taken),
        .rd_target (pred_target),
        .wr_en     (train),
        .wr_idx    (id2_pc[IDX_W+1:2]),
        .wr_tag    (id2_pc[IDX_W+2 +: TAG_W]),
        .wr_taken  (taken),
        .wr_target (id2_jmp_target)
    );

    // Redirects beat the stall; a not-taken fix-up skips the delay slot packet.
    always_comb begin
        next_pc = (pc & ~(FB - 32'd1)) + FB;
        if (exception_pc_ena)
            next_pc = exception_pc;
        else if (mispred && taken)
            next_pc = id2_jmp_target;
        else if (mispred)
            next_pc = id2_pc + (FB << 1);
        else if (fetch_stall)
            next_pc = pc;
        else if (pred_taken)
            next_pc = pred_target;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            pc <= RESET_PC;
        else
            pc <= next_pc;
    end

endmodule

// File: tb/tb_npc_bpu.sv
// Directed self-checking bench for npc_bpu.
// Drives inputs #1 after posedge, checks mid-cycle and #1 after the next edge.
module tb_npc_bpu;
    import npc_bpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_stall;
    logic        exception_pc_ena;
    logic [31:0] exception_pc;
    logic        id2_valid;
    logic [31:0] id2_pc;
    logic        id2_is_branch;
    logic        id2_is_jr;
    logic        id2_is_j_imme;
    logic [3:0]  id2_branch_sel;
    logic [31:0] id2_rs_data;
    logic [31:0] id2_rt_data;
    logic [31:0] id2_jmp_target;
    logic        id2_pred_taken;
    logic [31:0] id2_pred_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] next_pc;
    logic        flush_req;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npc_bpu dut (
        .clk              (clk),
        .resetn           (resetn),
        .fetch_stall      (fetch_stall),
        .exception_pc_ena (exception_pc_ena),
        .exception_pc     (exception_pc),
        .id2_valid        (id2_valid),
        .id2_pc           (id2_pc),
        .id2_is_branch    (id2_is_branch),
        .id2_is_jr        (id2_is_jr),
        .id2_is_j_imme    (id2_is_j_imme),
        .id2_branch_sel   (id2_branch_sel),
        .id2_rs_data      (id2_rs_data),
        .id2_rt_data      (id2_rt_data),
        .id2_jmp_target   (id2_jmp_target),
        .id2_pred_taken   (id2_pred_taken),
        .id2_pred_target  (id2_pred_target),
        .pc               (pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .next_pc          (next_pc),
        .flush_req        (flush_req)
    );

    task automatic idle();
        fetch_stall      = 1'b0;
        exception_pc_ena = 1'b0;
        exception_pc     = 32'd0;
        id2_valid        = 1'b0;
        id2_pc           = 32'd0;
        id2_is_branch    = 1'b0;
        id2_is_jr        = 1'b0;
        id2_is_j_imme    = 1'b0;
        id2_branch_sel   = 4'd0;
        id2_rs_data      = 32'd0;
        id2_rt_data      = 32'd0;
        id2_jmp_target   = 32'd0;
        id2_pred_taken   = 1'b0;
        id2_pred_target  = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the fetch PC through the exception redirect (no ID2 activity).
    task automatic set_pc(input logic [31:0] a);
        idle();
        exception_pc_ena = 1'b1;
        exception_pc     = a;
        tick();
        idle();
        #2;
    endtask

    task automatic branch(input logic [3:0] sel, input logic [31:0] bpc,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptgt);
        idle();
        id2_valid       = 1'b1;
        id2_is_branch   = 1'b1;
        id2_pc          = bpc;
        id2_branch_sel  = sel;
        id2_rs_data     = rs;
        id2_rt_data     = rt;
        id2_jmp_target  = tgt;
        id2_pred_taken  = pt;
        id2_pred_target = ptgt;
        #2;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL reset_pc got %h want %h", pc, 32'hBFC0_0000);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_pred got %b want 0", pred_taken);
        end
        resetn = 1'b1;
        #2;
        checks++;
        if (next_pc !== 32'hBFC0_0008) begin
            failures++;
            $display("FAIL reset_next got %h want %h", next_pc, 32'hBFC0_0008);
        end
    endtask

    task automatic test_sequential();
        tick();
        checks++;
        if (pc !== 32'hBFC0_0008) begin
            failures++;
            $display("FAIL seq_pc1 got %h want %h", pc, 32'hBFC0_0008);
        end
        tick();
        checks++;
        if (pc !== 32'hBFC0_0010) begin
            failures++;
            $display("FAIL seq_pc2 got %h want %h", pc, 32'hBFC0_0010);
        end
        set_pc(32'hBFC0_0004);
        checks++;
        if (next_pc !== 32'hBFC0_0008) begin
            failures++;
            $display("FAIL seq_unaligned got %h want %h", next_pc, 32'hBFC0_0008);
        end
        set_pc(32'hFFFF_FFF8);
        checks++;
        if (next_pc !== 32'h0000_0000) begin
            failures++;
            $display("FAIL seq_wrap got %h want 0", next_pc);
        end
        fetch_stall = 1'b1;
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL stall_hold got %h want %h", pc, 32'hFFFF_FFF8);
        end
        idle();
    endtask

    task automatic test_alloc();
        branch(BRANCH_SEL_BEQ, 32'hBFC0_0010, 32'd5, 32'd5,
               32'hBFC0_0100, 1'b0, 32'd0);
        checks++;
        if (flush_req !== 1'b1 || next_pc !== 32'hBFC0_0100) begin
            failures++;
            $display("FAIL alloc_redirect got flush=%b next=%h want 1 %h",
                     flush_req, next_pc, 32'hBFC0_0100);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'hBFC0_0100) begin
            failures++;
            $display("FAIL alloc_pc got %h want %h", pc, 32'hBFC0_0100);
        end
    endtask

    task automatic test_predict_hit();
        set_pc(32'hBFC0_0010);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'hBFC0_0100) begin
            failures++;
            $display("FAIL hit_pred got %b %h want 1 %h",
                     pred_taken, pred_target, 32'hBFC0_0100);
        end
        checks++;
        if (next_pc !== 32'hBFC0_0100) begin
            failures++;
            $display("FAIL hit_next got %h want %h", next_pc, 32'hBFC0_0100);
        end
        // Two correctly predicted taken resolves: 10 -> 11 -> 11.
        for (int i = 0; i < 2; i++) begin
            branch(BRANCH_SEL_BEQ, 32'hBFC0_0010, 32'd5, 32'd5,
                   32'hBFC0_0100, 1'b1, 32'hBFC0_0100);
            checks++;
            if (flush_req !== 1'b0) begin
                failures++;
                $display("FAIL hit_noflush%0d got %b want 0", i, flush_req);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_not_taken();
        logic [1:0] exp_pred;
        exp_pred = 2'b01;
        // 11 -> 10 still predicts taken; 10 -> 01 no longer does.
        for (int i = 0; i < 2; i++) begin
            branch(BRANCH_SEL_BNE, 32'hBFC0_0010, 32'd5, 32'd5,
                   32'hBFC0_0100, 1'b1, 32'hBFC0_0100);
            checks++;
            if (flush_req !== 1'b1 || next_pc !== 32'hBFC0_0020) begin
                failures++;
                $display("FAIL nt_redirect%0d got flush=%b next=%h want 1 %h",
                         i, flush_req, next_pc, 32'hBFC0_0020);
            end
            tick();
            checks++;
            if (pc !== 32'hBFC0_0020) begin
                failures++;
                $display("FAIL nt_pc%0d got %h want %h", i, pc, 32'hBFC0_0020);
            end
            set_pc(32'hBFC0_0010);
            checks++;
            if (pred_taken !== exp_pred[i] || pred_target !== 32'hBFC0_0100) begin
                failures++;
                $display("FAIL nt_ctr%0d got %b %h want %b %h", i, pred_taken,
                         pred_target, exp_pred[i], 32'hBFC0_0100);
            end
        end
    endtask

    task automatic test_exception_wins();
        branch(BRANCH_SEL_BEQ, 32'hBFC0_0040, 32'd1, 32'd1,
               32'hBFC0_0400, 1'b0, 32'd0);
        fetch_stall      = 1'b1;
        exception_pc_ena = 1'b1;
        exception_pc     = 32'h8000_0180;
        #1;
        checks++;
        if (flush_req !== 1'b1 || next_pc !== 32'h8000_0180) begin
            failures++;
            $display("FAIL exc_next got flush=%b next=%h want 1 %h",
                     flush_req, next_pc, 32'h8000_0180);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'h8000_0180) begin
            failures++;
            $display("FAIL exc_pc got %h want %h", pc, 32'h8000_0180);
        end
        set_pc(32'hBFC0_0040);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            failures++;
            $display("FAIL exc_no_train got %b %h want 0 0",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_jumps();
        idle();
        id2_valid       = 1'b1;
        id2_is_jr       = 1'b1;
        id2_pc          = 32'hBFC0_0060;
        id2_jmp_target  = 32'hBFC0_0300;
        id2_pred_taken  = 1'b1;
        id2_pred_target = 32'hBFC0_0200;
        #2;
        checks++;
        if (flush_req !== 1'b1 || next_pc !== 32'hBFC0_0300) begin
            failures++;
            $display("FAIL jr_target got flush=%b next=%h want 1 %h",
                     flush_req, next_pc, 32'hBFC0_0300);
        end
        id2_is_jr       = 1'b0;
        id2_is_j_imme   = 1'b1;
        id2_pred_target = 32'hBFC0_0300;
        #2;
        checks++;
        if (flush_req !== 1'b0) begin
            failures++;
            $display("FAIL j_ok got flush=%b want 0", flush_req);
        end
        tick();
        idle();
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp;
    } cond_t;

    task automatic test_conditions();
        cond_t v [13];
        v[0]  = '{BRANCH_SEL_BEQ,    32'd5,         32'd6, 1'b0};
        v[1]  = '{BRANCH_SEL_BNE,    32'd5,         32'd6, 1'b1};
        v[2]  = '{BRANCH_SEL_BGEZ,   32'd0,         32'd0, 1'b1};
        v[3]  = '{BRANCH_SEL_BGEZ,   32'h8000_0000, 32'd0, 1'b0};
        v[4]  = '{BRANCH_SEL_BGTZ,   32'd0,         32'd0, 1'b0};
        v[5]  = '{BRANCH_SEL_BGTZ,   32'd1,         32'd0, 1'b1};
        v[6]  = '{BRANCH_SEL_BLEZ,   32'd0,         32'd0, 1'b1};
        v[7]  = '{BRANCH_SEL_BLEZ,   32'd1,         32'd0, 1'b0};
        v[8]  = '{BRANCH_SEL_BLEZ,   32'hFFFF_FFFF, 32'd0, 1'b1};
        v[9]  = '{BRANCH_SEL_BLTZ,   32'hFFFF_FFFF, 32'd0, 1'b1};
        v[10] = '{BRANCH_SEL_BLTZ,   32'd0,         32'd0, 1'b0};
        v[11] = '{BRANCH_SEL_BGEZAL, 32'd7,         32'd0, 1'b1};
        v[12] = '{BRANCH_SEL_BLTZAL, 32'd7,         32'd0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            branch(v[i].sel, 32'hBFC0_0080, v[i].rs, v[i].rt,
                   32'hBFC0_0500, 1'b0, 32'd0);
            checks++;
            if (flush_req !== v[i].exp) begin
                failures++;
                $display("FAIL cond%0d sel=%0d got %b want %b",
                         i, v[i].sel, flush_req, v[i].exp);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_run();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (pc !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL rst2_pc got %h want %h", pc, 32'hBFC0_0000);
        end
        set_pc(32'hBFC0_0010);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            failures++;
            $display("FAIL rst2_miss10 got %b %h want 0 0",
                     pred_taken, pred_target);
        end
        set_pc(32'hBFC0_0080);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            failures++;
            $display("FAIL rst2_miss80 got %b %h want 0 0",
                     pred_taken, pred_target);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_alloc();
        test_predict_hit();
        test_not_taken();
        test_exception_wins();
        test_jumps();
        test_conditions();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
